// File: rtl/ysyx_25040129_ifu_prefetch_pkg.sv
// Shared types and constants for the prefetching IFU: bus codes, AR FSM states, queue entry layout.
package ysyx_25040129_ifu_prefetch_pkg;

   localparam logic [31:0] FLASH_START = 32'h3000_0000;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_REQ  = 1'b1
   } ar_state_e;

   typedef struct packed {
      logic        err;
      logic [31:0] pc;
      logic [31:0] inst;
   } ifq_entry_t;

   localparam int unsigned ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/ysyx_25040129_ifu_fifo.sv
// Synchronous FIFO with occupancy count and a clear that wins over push/pop.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module ysyx_25040129_ifu_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || pop_i);

   always_ff @(posedge clk) begin
      if (!rst || clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= inc(wr_q);
         if (do_pop)  rd_q <= inc(rd_q);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/ysyx_25040129_ifu_prefetch.sv
// Prefetching IFU: multiple AXI4-Lite reads in flight, in-order instruction queue, flush with response drop.
// IFU_BYPASS_EN forwards a response straight to IDU when the queue is empty; ysyx_25040129_DPI reports bus errors.
module ysyx_25040129_ifu_prefetch
   import ysyx_25040129_ifu_prefetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = FLASH_START,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_err,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
);

   localparam int unsigned QCW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

   ar_state_e      state_q, state_d;
   logic [31:0]    fetch_pc_q, fetch_pc_d, araddr_q, araddr_d;
   logic [OCW-1:0] drop_q, drop_d, outstanding;
   logic [QCW-1:0] occupancy;
   logic [31:0]    pc_head, inflight, credit_used;
   logic           pc_full, pc_empty, q_full, q_empty;
   logic           ar_fire, r_fire, raise, resp_keep, byp, q_push, q_pop;
   ifq_entry_t     q_wdata, q_head, head_out;

   assign ar_fire = arvalid && arready;
   assign r_fire  = rvalid && !pc_empty;

   // inflight: requests owed once this cycle's accept/return settle; credit_used counts queue slots already promised
   assign inflight    = 32'(outstanding) + 32'(arvalid) - 32'(r_fire);
   assign credit_used = 32'(outstanding) + 32'(occupancy) + 32'(arvalid);
   assign raise = !flush && (drop_q == '0) && (!arvalid || arready)
                  && (inflight < MAX_OUTSTANDING) && (credit_used < FIFO_DEPTH)
                  && !q_full && (!pc_full || rvalid);

   // Shadows every accepted AR so each response picks up its own PC, including ones being dropped
   ysyx_25040129_ifu_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ar_fire),
      .wdata_i (araddr_q),
      .pop_i   (rvalid),
      .clear_i (1'b0),
      .rdata_o (pc_head),
      .full_o  (pc_full),
      .empty_o (pc_empty),
      .count_o (outstanding)
   );

   ysyx_25040129_ifu_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_inst_q (
      .clk     (clk),
      .rst     (rst),
      .push_i  (q_push),
      .wdata_i (q_wdata),
      .pop_i   (q_pop),
      .clear_i (flush),
      .rdata_o (q_head),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (occupancy)
   );

   assign resp_keep = rvalid && (drop_q == '0) && !flush;
   assign q_wdata   = '{err: (rresp != RESP_OKAY), pc: pc_head, inst: rdata};
`ifdef IFU_BYPASS_EN
   assign byp    = resp_keep && q_empty;
   assign q_push = resp_keep && !(byp && inst_ready);
`else
   assign byp    = 1'b0;
   assign q_push = resp_keep;
`endif
   assign inst_valid = !flush && (!q_empty || byp);
   assign q_pop      = inst_valid && inst_ready && !q_empty;

   always_comb begin
      head_out = '0;
      if (!q_empty)  head_out = q_head;
      else if (byp)  head_out = q_wdata;
      inst     = head_out.inst;
      inst_pc  = head_out.pc;
      inst_err = head_out.err;
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= AR_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         AR_IDLE: if (raise)   state_d = AR_REQ;
         AR_REQ:  if (arready) state_d = raise ? AR_REQ : AR_IDLE;
         default:              state_d = AR_IDLE;
      endcase
   end

   always_comb begin
      arvalid = (state_q == AR_REQ);
      araddr  = araddr_q;
      rready  = 1'b1;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      araddr_d   = araddr_q;
      drop_d     = drop_q;
      if (raise) begin
         araddr_d   = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (flush) begin
         fetch_pc_d = flush_target;
         // Accepted-or-presented ARs all still return a word; a presented AR is never withdrawn
         drop_d = outstanding + OCW'(arvalid) - OCW'(r_fire);
      end else if (rvalid && drop_q != '0) begin
         drop_d = drop_q - OCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         araddr_q   <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         araddr_q   <= araddr_d;
         drop_q     <= drop_d;
      end
   end

`ifdef ysyx_25040129_DPI
   always_ff @(posedge clk) begin
      if (rst && rvalid && rresp != RESP_OKAY) $error("ifu: bus error fetching %h", pc_head);
   end
`endif

endmodule
